// File: rtl/button_repeat.sv
// button_repeat
//
// Turns a clean, debounced button level into single-cycle events for the
// paddle position logic: a press strobe, auto-repeat strobes while the
// button stays down, and a release strobe. The paddle logic moves one step
// per o_step and needs no timers of its own.
//
// Parameters
//   HOLD_DELAY    : cycles from the press edge to the first repeat (>= 1)
//   REPEAT_PERIOD : cycles between consecutive repeats (>= 1)
//
// Ports
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_level   : debounced button level, 1 = pressed, synchronous to i_clk
//   o_press   : one-cycle strobe on press
//   o_repeat  : one-cycle strobe per auto-repeat
//   o_step    : o_press | o_repeat
//   o_release : one-cycle strobe on release
//   o_held    : high while the button is considered held (HOLD or REPEAT)
//
// state  | meaning
// -------+-------------------------------------------
// IDLE   | waiting for a press
// HOLD   | pressed, timing out HOLD_DELAY to first repeat
// REPEAT | pressed, emitting a repeat every REPEAT_PERIOD

module button_repeat #(
    parameter int HOLD_DELAY    = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_press,
    output logic o_repeat,
    output logic o_step,
    output logic o_release,
    output logic o_held
);

    localparam int MAX_DELAY = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CW        = $clog2(MAX_DELAY) + 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          press_nxt;
    logic          repeat_nxt;
    logic          release_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            count     <= '0;
            o_press   <= 1'b0;
            o_repeat  <= 1'b0;
            o_step    <= 1'b0;
            o_release <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            o_press   <= press_nxt;
            o_repeat  <= repeat_nxt;
            o_step    <= press_nxt | repeat_nxt;
            o_release <= release_nxt;
            o_held    <= (state_nxt != IDLE);
        end
    end

    // Release is tested before the terminal count so that a button let go
    // on the same edge a repeat would have fired yields only a release.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        press_nxt   = 1'b0;
        repeat_nxt  = 1'b0;
        release_nxt = 1'b0;

        case (state)
            IDLE: begin
                count_nxt = '0;
                if (i_level) begin
                    state_nxt = HOLD;
                    press_nxt = 1'b1;
                end
            end

            HOLD: begin
                if (!i_level) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    count_nxt   = '0;
                end else if (count == HOLD_LAST) begin
                    state_nxt  = REPEAT;
                    repeat_nxt = 1'b1;
                    count_nxt  = '0;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end

            REPEAT: begin
                if (!i_level) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    count_nxt   = '0;
                end else if (count == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    count_nxt  = '0;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_repeat.sv
// Testbench for button_repeat: two instances (4/2 and 1/1 timing) share one
// button level. An event-level model predicts each cycle's outputs from the
// time elapsed since the press; directed windows pin exact event offsets.

module tb_button_repeat;

    localparam int HA = 4;
    localparam int PA = 2;
    localparam int HB = 1;
    localparam int PB = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic level = 1'b0;

    logic a_press, a_repeat, a_step, a_release, a_held;
    logic b_press, b_repeat, b_step, b_release, b_held;

    int checks   = 0;
    int failures = 0;

    button_repeat #(.HOLD_DELAY(HA), .REPEAT_PERIOD(PA)) dut_a (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_level  (level),
        .o_press  (a_press),
        .o_repeat (a_repeat),
        .o_step   (a_step),
        .o_release(a_release),
        .o_held   (a_held)
    );

    button_repeat #(.HOLD_DELAY(HB), .REPEAT_PERIOD(PB)) dut_b (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_level  (level),
        .o_press  (b_press),
        .o_repeat (b_repeat),
        .o_step   (b_step),
        .o_release(b_release),
        .o_held   (b_held)
    );

    always #5 clk = ~clk;

    // Output vector order: {press, repeat, step, release, held}.
    // age = edges since the press edge; repeats land at age H, H+P, H+2P...
    function automatic logic [4:0] model_out(input logic was_held, input logic lvl,
                                             input int age, input int h, input int p);
        logic pr, rp, rl;
        pr = !was_held && lvl;
        rl = was_held && !lvl;
        rp = was_held && lvl && (age >= h) && (((age - h) % p) == 0);
        return {pr, rp, pr | rp, rl, lvl};
    endfunction

    int         edge_n = 0;
    int         e0_a   = 0;
    int         e0_b   = 0;
    logic       m_held_a = 1'b0;
    logic       m_held_b = 1'b0;
    logic [4:0] exp_a  = '0;
    logic [4:0] exp_b  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_held_a <= 1'b0;
            m_held_b <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
        end else begin
            edge_n   <= edge_n + 1;
            exp_a    <= model_out(m_held_a, level, edge_n - e0_a, HA, PA);
            exp_b    <= model_out(m_held_b, level, edge_n - e0_b, HB, PB);
            if (!m_held_a && level) e0_a <= edge_n;
            if (!m_held_b && level) e0_b <= edge_n;
            m_held_a <= level;
            m_held_b <= level;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ({a_press, a_repeat, a_step, a_release, a_held} !== exp_a) begin
                failures++;
                $display("FAIL model_a t=%0t got %b want %b", $time,
                         {a_press, a_repeat, a_step, a_release, a_held}, exp_a);
            end
            checks++;
            if ({b_press, b_repeat, b_step, b_release, b_held} !== exp_b) begin
                failures++;
                $display("FAIL model_b t=%0t got %b want %b", $time,
                         {b_press, b_repeat, b_step, b_release, b_held}, exp_b);
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, expv);
        end
    endtask

    logic [4:0] rec_a [0:15];
    logic [4:0] rec_b [0:15];
    int         rec_n = 0;

    // Called just after a negedge. Level is sampled high at E0..E0+hi-1 and
    // low from E0+hi; rec[k] holds the outputs registered at edge E0+k.
    task automatic window(input int hi, input int total);
        level = 1'b1;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            rec_a[k] = {a_press, a_repeat, a_step, a_release, a_held};
            rec_b[k] = {b_press, b_repeat, b_step, b_release, b_held};
            if (k == hi - 1) level = 1'b0;
        end
        rec_n = total;
    endtask

    // bitpos: 4 press, 3 repeat, 2 step, 1 release, 0 held
    function automatic int mask_a(input int bitpos);
        int m = 0;
        for (int k = 0; k < rec_n; k++) if (rec_a[k][bitpos]) m |= (1 << k);
        return m;
    endfunction

    function automatic int mask_b(input int bitpos);
        int m = 0;
        for (int k = 0; k < rec_n; k++) if (rec_b[k][bitpos]) m |= (1 << k);
        return m;
    endfunction

    task automatic idle(input int n);
        level = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_a", {a_press, a_repeat, a_step, a_release, a_held}, 0);
        check("reset_b", {b_press, b_repeat, b_step, b_release, b_held}, 0);
        rst_n = 1'b1;
        idle(3);

        // Long hold, 4/2
        window(10, 12);
        check("long_press",   mask_a(4), 32'h1);
        check("long_repeat",  mask_a(3), 32'h150);
        check("long_release", mask_a(1), 32'h400);
        check("long_steps",   $countones(mask_a(2)), 4);
        idle(3);

        // Short press, 4/2
        window(3, 8);
        check("short_press",   mask_a(4), 32'h1);
        check("short_repeat",  mask_a(3), 32'h0);
        check("short_release", mask_a(1), 32'h8);
        check("short_held",    mask_a(0), 32'h7);
        idle(3);

        // Release sampled exactly where the second repeat would land
        window(6, 10);
        check("coll_release", mask_a(1), 32'h40);
        check("coll_repeat",  mask_a(3), 32'h10);
        idle(3);

        // Minimum parameters on the 1/1 instance
        window(5, 8);
        check("min_press",   mask_b(4), 32'h1);
        check("min_repeat",  mask_b(3), 32'h1e);
        check("min_step",    mask_b(2), 32'h1f);
        check("min_release", mask_b(1), 32'h20);
        idle(3);

        // Single-cycle pulse
        window(1, 6);
        check("pulse_press_a",   mask_a(4), 32'h1);
        check("pulse_release_a", mask_a(1), 32'h2);
        check("pulse_repeat_a",  mask_a(3), 32'h0);
        check("pulse_release_b", mask_b(1), 32'h2);
        check("pulse_repeat_b",  mask_b(3), 32'h0);
        idle(3);

        // Reset asserted mid-REPEAT with the button still down
        level = 1'b1;
        repeat (9) @(negedge clk);
        check("pre_reset_held", a_held, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", {a_press, a_repeat, a_step, a_release, a_held}, 0);
        check("async_reset_b", {b_press, b_repeat, b_step, b_release, b_held}, 0);
        @(negedge clk);
        check("reset_no_release", a_release, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_press_a", a_press, 1);
        check("post_reset_press_b", b_press, 1);
        check("post_reset_held_a",  a_held, 1);
        idle(3);

        // Random level runs, with occasional asynchronous resets
        for (int r = 0; r < 160; r++) begin
            level = ~level;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                #3 rst_n = 1'b0;
                #1;
                check("rand_reset_a", {a_press, a_repeat, a_step, a_release, a_held}, 0);
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_repeat.md
# button_repeat

- Converts a clean, debounced button level into single-cycle control events: a press strobe, periodic auto-repeat strobes while the button is held, and a release strobe.
- Sits directly downstream of the debounce filter on each paddle button and feeds the paddle position logic.
- The paddle logic moves one step per `o_step` and never needs its own timers.

## Interface
- `HOLD_DELAY`, default 12500000: cycles from press to the first repeat; must be ≥ 1.
- `REPEAT_PERIOD`, default 2500000: cycles between consecutive repeats; must be ≥ 1.
- `i_clk`, input, 1: system clock. All logic is on the rising edge.
- `i_rst_n`, input, 1: reset. Asynchronous, active-low.
- `i_level`, input, 1: debounced button level, 1 = pressed. Already synchronous to `i_clk`.
- `o_press`, output, 1: one-cycle strobe on press.
- `o_repeat`, output, 1: one-cycle strobe for each auto-repeat.
- `o_step`, output, 1: `o_press` OR `o_repeat`, registered, in the same cycle as either.
- `o_release`, output, 1: one-cycle strobe on release.
- `o_held`, output, 1: 1 while the FSM is in HOLD or REPEAT.

## Operation
- Internal counter width is `$clog2(max(HOLD_DELAY, REPEAT_PERIOD))+1` bits, unsigned.
- The counter never exceeds `max-1`.
- The counter is cleared on every state change.
- FSM states:
  - **IDLE**: waiting for a press.
  - **HOLD**: pressed, waiting for the first repeat.
  - **REPEAT**: generating periodic repeats.
- IDLE:
  - On an edge with `i_level`=1: go to HOLD, count←0, `o_press`=1 and `o_step`=1 for the next cycle.
  - On an edge with `i_level`=0: stay in IDLE, no strobes.
- HOLD:
  - `i_level`=0: go to IDLE, `o_release`=1, count←0.
  - Else if count == `HOLD_DELAY`-1: go to REPEAT, `o_repeat`=1 and `o_step`=1, count←0.
  - Else: count←count+1.
- REPEAT:
  - `i_level`=0: go to IDLE, `o_release`=1, count←0.
  - Else if count == `REPEAT_PERIOD`-1: `o_repeat`=1 and `o_step`=1, count←0.
  - Else: count←count+1.
- Priority: release beats repeat on the same edge. A repeat is never emitted in the cycle a release is detected.
- All strobes are registered and high for exactly one cycle. No two of press, repeat and release are ever high together.
- `o_held` is registered and equals (next state ≠ IDLE).
- A level held high across reset deassertion is a new press: `o_press` fires after the first edge following reset release.
- A one-cycle high pulse on `i_level` produces `o_press`, then `o_release` on the next edge. There is no minimum hold time.

## Timing
- Reset (`i_rst_n`=0, asynchronous):
  - State → IDLE, count → 0.
  - `o_press`, `o_repeat`, `o_step`, `o_release`, `o_held` all go to 0 immediately, without a clock.
- Reset asserted mid-hold: outputs clear immediately and no `o_release` is generated.
- Latency: an `i_level` change sampled at edge E appears on the outputs after edge E (1 cycle).
- Label the press edge E0. The first repeat is registered at edge E0+`HOLD_DELAY`.
- Subsequent repeats are registered at E0+`HOLD_DELAY`+k·`REPEAT_PERIOD`, for k ≥ 1.
- Release is registered at the first edge that samples `i_level`=0.
- `o_held` falls on that same edge.
- With `HOLD_DELAY`=1 and `REPEAT_PERIOD`=1, `o_step` is high every cycle while the button is held.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-REPEAT with `i_level`=1.
  - All outputs go to 0 asynchronously.
  - Release `i_rst_n` with `i_level`=1: `o_press` pulses after the first edge.
- **Short press** (HOLD_DELAY=4, REPEAT_PERIOD=2): `i_level` high for 3 cycles.
  - One `o_press`, zero `o_repeat`, one `o_release` 3 cycles after the press.
  - `o_held` high for 3 cycles.
- **Long hold** (4/2): `i_level` high for 10 cycles starting at E0.
  - `o_press` at E0.
  - `o_repeat` at E0+4, E0+6, E0+8.
  - `o_release` at E0+10.
  - `o_step` count = 4.
- **Release collision** (4/2): drop `i_level` so that it is sampled 0 at exactly E0+6.
  - `o_release` at E0+6, no `o_repeat` at E0+6.
- **Minimum parameters** (1/1): hold for 5 cycles.
  - `o_press` at E0, `o_repeat` at E0+1 through E0+4, `o_step` high 5 consecutive cycles.
- **Single-cycle pulse:** `i_level` high for 1 cycle.
  - `o_press` at E0, `o_release` at E0+1, then IDLE with no further strobes.
